// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency unified memory between the
// instruction-fetch stage and the MEM stage (LW/SW) of the 16-bit pipeline.
// One requester is granted at a time. Each access is sequenced through
// IDLE -> ACCESS -> WAIT -> RESP, and a registered valid pulse plus read data
// is returned to the owner. Data requests normally win. A starvation counter
// forces a fetch grant after STARVE_MAX consecutive data grants that were
// made while a fetch was pending.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   if_req, if_addr            fetch request/address, held until if_valid
//   if_valid, if_rdata         fetch completion pulse and instruction word
//   d_req, d_we, d_addr,
//   d_wdata                    data request (1=store), held until d_valid
//   d_valid, d_rdata           data completion pulse and load data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata       single-port memory interface
//   stall_if, stall_mem        combinational freeze lines for IF / MEM
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_mem
);

    // $clog2(MEM_LAT) bits are enough to hold MEM_LAT-1; keep at least one bit.
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          own_d;
    logic          we_lat;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_d;
    logic          grant_f;

    // Grant decision, only meaningful in IDLE. Data loses only when a fetch
    // is pending and has already been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_d = 1'b0;
        grant_f = 1'b0;
        if (state == IDLE) begin
            if (d_req && !(if_req && (starve_cnt == SW'(STARVE_MAX)))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_f = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_d || grant_f) state_next = ACCESS;
            ACCESS:  state_next = WAIT;
            WAIT:    if (lat_cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered datapath. mem_en/mem_we and the valid pulses default low every
    // cycle, so each is high for exactly the one cycle after the edge that set it.
    // The grant edge loads the address, so mem_addr/mem_wdata are already stable
    // during ACCESS and simply hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            own_d      <= 1'b0;
            we_lat     <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        own_d     <= 1'b1;
                        we_lat    <= d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (!if_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != SW'(STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end else if (grant_f) begin
                        own_d      <= 1'b0;
                        we_lat     <= 1'b0;
                        mem_en     <= 1'b1;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
                ACCESS: begin
                    lat_cnt <= LW'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (own_d) begin
                            d_valid <= 1'b1;
                            if (!we_lat) d_rdata <= mem_rdata;
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule
